uart_tx_cfg: RTL and testbench

Parametrised UART transmitter, next generation of the fixed 8N1 `uart_tx`/`baud_gen` pair. It embeds its own bit-period counter, so it runs from the system clock rather than a derived `baud_clk`. Data width and stop-bit count are configurable, and an optional parity bit can be compiled in. It accepts words via a ready/valid handshake, so the word source no longer has to track `fsm_clk` edges.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_tx_cfg.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
// Optional parity is compiled in with the macro UART_TX_PARITY_EN.
package uart_pkg;

    // Transmitter state encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Number of parity bit periods in a frame for this build
`ifdef UART_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Total clocks from the first start-bit clock to the last stop-bit clock
    function automatic int frame_len(input int clks_per_bit,
                                     input int data_bits,
                                     input int stop_bits,
                                     input int parity_bits);
        return clks_per_bit * (1 + data_bits + parity_bits + stop_bits);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// A clear restarts the count so the next bit period begins on the following clock.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == TERMINAL);

    // Free-running modulo counter, restarted on reset or clear
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with ready/valid word input.
// Frame: start, DATA_BITS payload LSB first, optional parity, STOP_BITS stop.
// Define UART_TX_PARITY_EN to compile in the parity bit (PARITY_ODD selects sense).
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_en,
    output logic                 ready,
    output logic                 o_bit,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    // Reject illegal configurations at elaboration
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY_ODD must be 0 or 1");
    end

    uart_state_e          state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic                 o_bit_n;
    logic                 tick;
    logic                 accept;

`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    assign ready  = (state == IDLE);
    assign busy   = (state != IDLE);
    assign accept = data_en && ready;

    // Clearing on accept phase-aligns every frame to its accept cycle
    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(accept),
        .tick (tick)
    );

    // State, shift register, index and registered serial output
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            o_bit <= 1'b1;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            idx   <= idx_n;
            o_bit <= o_bit_n;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the accepted word, captured once so the shifter is free to move
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= (^data_in) ^ (PARITY_ODD != 0);
        end
    end
`endif

    // Next-state logic; o_bit_n is decoded from the next state so o_bit is a clean flop
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        o_bit_n = 1'b1;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    shreg_n = data_in;
                    idx_n   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx == LAST_DATA) begin
                        idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n   = idx + 1'b1;
                        shreg_n = shreg >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                // idx counts stop-bit periods here
                if (tick) begin
                    if (idx == LAST_STOP) begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        case (state_n)
            START:   o_bit_n = 1'b0;
            DATA:    o_bit_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  o_bit_n = parity_q;
`endif
            default: o_bit_n = 1'b1;
        endcase
    end

`ifndef SYNTHESIS
    localparam int FRAME_CLKS = frame_len(CLKS_PER_BIT, DATA_BITS, STOP_BITS, PARITY_BITS);

    int busy_cycles;

    // Every completed frame must hold busy for exactly one frame length
    always_ff @(posedge clk) begin
        if (rst || !busy) begin
            busy_cycles <= 0;
        end else begin
            busy_cycles <= busy_cycles + 1;
        end
        if (!rst && state == STOP && state_n == IDLE) begin
            assert (busy_cycles + 1 == FRAME_CLKS)
            else $error("uart_tx_cfg: busy window %0d differs from frame length %0d",
                        busy_cycles + 1, FRAME_CLKS);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three instances with different configurations.
// Works in both builds (with and without UART_TX_PARITY_EN).
module tb_uart_tx_cfg;
    import uart_pkg::*;

    localparam int C0 = 4;
    localparam int C1 = 3;
    localparam int F0 = frame_len(C0, 8, 1, PARITY_BITS);

`ifdef UART_TX_PARITY_EN
    localparam int          N8         = 11;
    localparam int          N5         = 9;
    localparam logic [15:0] EXP_T_EVEN = 16'h06A8;
    localparam logic [15:0] EXP_T_ODD  = 16'h04A8;
    localparam logic [15:0] EXP_A5     = 16'h054A;
    localparam logic [15:0] EXP_13     = 16'h01E6;
`else
    localparam int          N8         = 10;
    localparam int          N5         = 8;
    localparam logic [15:0] EXP_T_EVEN = 16'h02A8;
    localparam logic [15:0] EXP_T_ODD  = 16'h02A8;
    localparam logic [15:0] EXP_A5     = 16'h034A;
    localparam logic [15:0] EXP_13     = 16'h00E6;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din0 = '0;
    logic [4:0] din1 = '0;
    logic [7:0] din2 = '0;
    logic       den  [3];
    logic       obit [3];
    logic       bsy  [3];
    logic       rdy  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(C0), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(din0), .data_en(den[0]),
        .ready(rdy[0]), .o_bit(obit[0]), .busy(bsy[0]));

    uart_tx_cfg #(.CLKS_PER_BIT(C1), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .data_in(din1), .data_en(den[1]),
        .ready(rdy[1]), .o_bit(obit[1]), .busy(bsy[1]));

    uart_tx_cfg #(.CLKS_PER_BIT(C0), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .rst(rst), .data_in(din2), .data_en(den[2]),
        .ready(rdy[2]), .o_bit(obit[2]), .busy(bsy[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int d, input logic [7:0] w);
        case (d)
            0:       din0 = w;
            1:       din1 = w[4:0];
            default: din2 = w;
        endcase
    endtask

    // Accept one word on instance d and check every clock of its frame
    task automatic check_frame(input int d, input logic [7:0] word, input logic [15:0] expv,
                               input int n, input int clks, input int pulse_at, input string tag);
        int cyc;
        chk({tag, "_idle_ready"}, 32'(rdy[d]), 1);
        set_word(d, word);
        den[d] = 1'b1;
        @(negedge clk);
        den[d] = 1'b0;
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < clks; c++) begin
                chk($sformatf("%s_bit%0d_c%0d", tag, i, c), 32'(obit[d]), 32'(expv[i]));
                chk($sformatf("%s_busy_c%0d", tag, cyc), 32'(bsy[d]), 1);
                chk($sformatf("%s_ready_c%0d", tag, cyc), 32'(rdy[d]), 0);
                if (cyc == pulse_at) begin
                    set_word(d, 8'hFF);
                    den[d] = 1'b1;
                end else begin
                    den[d] = 1'b0;
                end
                cyc++;
                @(negedge clk);
            end
        end
        den[d] = 1'b0;
        chk({tag, "_end_busy"}, 32'(bsy[d]), 0);
        chk({tag, "_end_ready"}, 32'(rdy[d]), 1);
        chk({tag, "_end_obit"}, 32'(obit[d]), 1);
    endtask

    logic [7:0] b2b_words [5];
    logic [7:0] dec;
    int         cnt;

    initial begin
        den[0] = 1'b0;
        den[1] = 1'b0;
        den[2] = 1'b0;
        b2b_words[0] = 8'h54;
        b2b_words[1] = 8'h61;
        b2b_words[2] = 8'h72;
        b2b_words[3] = 8'h74;
        b2b_words[4] = 8'h7A;

        // Reset state on all instances
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_obit%0d", d), 32'(obit[d]), 1);
            chk($sformatf("rst_ready%0d", d), 32'(rdy[d]), 1);
            chk($sformatf("rst_busy%0d", d), 32'(bsy[d]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // 8N1 "T" (plus parity bit when compiled in)
        check_frame(0, 8'h54, EXP_T_EVEN, N8, C0, -1, "t8n1");

        // 5 data bits, 2 stop bits, 3 clocks per bit
        check_frame(1, 8'h13, EXP_13, N5, C1, -1, "d5s2");

        // Odd-parity instance sending "T"
        check_frame(2, 8'h54, EXP_T_ODD, N8, C0, -1, "t_odd");

        // Back-to-back frames with data_en held high
        den[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("b2b_ready%0d", k), 32'(rdy[0]), 1);
            chk($sformatf("b2b_idle_obit%0d", k), 32'(obit[0]), 1);
            din0 = b2b_words[k];
            @(negedge clk);
            cnt = 0;
            dec = '0;
            while (!rdy[0] && cnt < 200) begin
                if (cnt == 0) chk($sformatf("b2b_start%0d", k), 32'(obit[0]), 0);
                if ((cnt % C0) == (C0 / 2) && (cnt / C0) >= 1 && (cnt / C0) <= 8)
                    dec[(cnt / C0) - 1] = obit[0];
                cnt++;
                @(negedge clk);
            end
            chk($sformatf("b2b_busy_len%0d", k), 32'(cnt), 32'(F0));
            chk($sformatf("b2b_byte%0d", k), 32'(dec), 32'(b2b_words[k]));
            if (k == 4) den[0] = 1'b0;
        end
        chk("b2b_final_ready", 32'(rdy[0]), 1);
        @(negedge clk);
        chk("b2b_no_extra_busy", 32'(bsy[0]), 0);

        // Reset and data_en together: reset wins
        rst = 1'b1;
        din0 = 8'h33;
        den[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        den[0] = 1'b0;
        chk("rst_en_ready", 32'(rdy[0]), 1);
        chk("rst_en_busy", 32'(bsy[0]), 0);
        chk("rst_en_obit", 32'(obit[0]), 1);
        @(negedge clk);
        chk("rst_en_busy_later", 32'(bsy[0]), 0);
        chk("rst_en_obit_later", 32'(obit[0]), 1);

        // Reset at clock 10 of a frame
        din0 = 8'h54;
        den[0] = 1'b1;
        @(negedge clk);
        den[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_obit_before_rst", 32'(obit[0]), 0);
        chk("mid_busy_before_rst", 32'(bsy[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_obit", 32'(obit[0]), 1);
        chk("mid_rst_ready", 32'(rdy[0]), 1);
        chk("mid_rst_busy", 32'(bsy[0]), 0);
        check_frame(0, 8'hA5, EXP_A5, N8, C0, -1, "after_rst");

        // data_en pulsed mid-frame with 0xFF is ignored
        check_frame(0, 8'h54, EXP_T_EVEN, N8, C0, 15, "pulse");
        for (int i = 0; i < 3 * C0; i++) begin
            chk($sformatf("pulse_idle_obit%0d", i), 32'(obit[0]), 1);
            chk($sformatf("pulse_idle_busy%0d", i), 32'(bsy[0]), 0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
